serial_minuend_recover: RTL and testbench

Bit-serial inverse of the team's full-subtractor datapath. It takes a difference word D and the subtrahend B that produced it, and rebuilds the minuend A = D + B (mod 2^WIDTH), LSB first, one bit per clock. It also returns the carry-out, which equals the borrow-out of the original A − B. It sits on the checking/recovery side of the subtractor path, behind a valid/ready handshake on both ends.

---
 rtl/fs_pkg.sv | 13 +
 rtl/full_adder_1bit.sv | 13 +
 rtl/serial_minuend_recover.sv | 141 ++++++++++++++
 tb/tb_serial_minuend_recover.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/fs_pkg.sv
// Shared definitions for the serial subtractor/recovery datapath:
// the controller state encoding and the default word width.
package fs_pkg;

    localparam int FS_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } fs_state_e;

endpackage : fs_pkg

// File: rtl/full_adder_1bit.sv
// Single-bit combinational full adder used as the serial loop's arithmetic cell.
module full_adder_1bit (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (a & cin) | (b & cin);

endmodule : full_adder_1bit

// File: rtl/serial_minuend_recover.sv
// Bit-serial recovery of the minuend A = D + B (mod 2^WIDTH), LSB first,
// with the carry-out reported as the original subtraction's borrow.
module serial_minuend_recover
    import fs_pkg::*;
#(
    parameter int WIDTH = FS_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] diff_in,
    input  logic [WIDTH-1:0] sub_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] minuend_out,
    output logic             carry_out
);

    localparam int              CW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0]   CNT_LAST = CW'(WIDTH - 1);

    fs_state_e          state_r;
    fs_state_e          nxt_state_s;
    logic [WIDTH-1:0]   d_sh_r;
    logic [WIDTH-1:0]   b_sh_r;
    logic [WIDTH-1:0]   res_r;
    logic [CW-1:0]      cnt_r;
    logic               carry_r;
    logic [WIDTH-1:0]   minuend_r;
    logic               carry_out_r;
    logic               sum_s;
    logic               cout_s;
    logic               last_bit_s;
    logic               in_ready_s;
    logic               out_valid_s;

    full_adder_1bit u_fa (
        .a    (d_sh_r[0]),
        .b    (b_sh_r[0]),
        .cin  (carry_r),
        .sum  (sum_s),
        .cout (cout_s)
    );

    assign last_bit_s = (cnt_r == CNT_LAST);

    // Controller state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= nxt_state_s;
        end
    end

    // Next-state decode; handshake flags are pure functions of the state.
    always_comb begin
        nxt_state_s = state_r;
        in_ready_s  = 1'b0;
        out_valid_s = 1'b0;
        case (state_r)
            IDLE: begin
                in_ready_s = 1'b1;
                if (in_valid) begin
                    nxt_state_s = RUN;
                end else begin
                    nxt_state_s = IDLE;
                end
            end
            RUN: begin
                if (last_bit_s) begin
                    nxt_state_s = DONE;
                end else begin
                    nxt_state_s = RUN;
                end
            end
            DONE: begin
                out_valid_s = 1'b1;
                if (out_ready) begin
                    nxt_state_s = IDLE;
                end else begin
                    nxt_state_s = DONE;
                end
            end
            default: begin
                nxt_state_s = IDLE;
            end
        endcase
    end

    // Serial datapath: operand shifters, running carry, bit counter, partial result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            d_sh_r  <= {WIDTH{1'b0}};
            b_sh_r  <= {WIDTH{1'b0}};
            res_r   <= {WIDTH{1'b0}};
            cnt_r   <= {CW{1'b0}};
            carry_r <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (in_valid) begin
                        d_sh_r  <= diff_in;
                        b_sh_r  <= sub_in;
                        cnt_r   <= {CW{1'b0}};
                        carry_r <= 1'b0;
                    end
                end
                RUN: begin
                    res_r   <= {sum_s, res_r[WIDTH-1:1]};
                    d_sh_r  <= {1'b0, d_sh_r[WIDTH-1:1]};
                    b_sh_r  <= {1'b0, b_sh_r[WIDTH-1:1]};
                    carry_r <= cout_s;
                    cnt_r   <= cnt_r + {{(CW-1){1'b0}}, 1'b1};
                end
                default: begin
                    carry_r <= carry_r;
                end
            endcase
        end
    end

    // Result holding register: only the final shift updates it, so the
    // published word stays stable through DONE and the following IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            minuend_r   <= {WIDTH{1'b0}};
            carry_out_r <= 1'b0;
        end else if ((state_r == RUN) && last_bit_s) begin
            minuend_r   <= {sum_s, res_r[WIDTH-1:1]};
            carry_out_r <= cout_s;
        end
    end

    assign in_ready    = in_ready_s;
    assign out_valid   = out_valid_s;
    assign minuend_out = minuend_r;
    assign carry_out   = carry_out_r;

endmodule : serial_minuend_recover

// File: tb/tb_serial_minuend_recover.sv
// Directed self-checking bench for serial_minuend_recover at WIDTH=8.
module tb_serial_minuend_recover;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] diff_in;
    logic [7:0] sub_in;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] minuend_out;
    logic       carry_out;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    serial_minuend_recover #(.WIDTH(8)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .diff_in     (diff_in),
        .sub_in      (sub_in),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .minuend_out (minuend_out),
        .carry_out   (carry_out)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Present one word while idle; lat = edges from acceptance until out_valid (20 = timeout).
    task automatic send_word(input logic [7:0] d, input logic [7:0] b, output int lat);
        diff_in  = d;
        sub_in   = b;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic release_word();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        diff_in = 8'h00; sub_in = 8'h00;
        #12;
        n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        n_cmp++; if (minuend_out !== 8'h00) begin n_bad++; $display("FAIL reset_minuend: got %h want 00", minuend_out); end
        n_cmp++; if (carry_out !== 1'b0) begin n_bad++; $display("FAIL reset_carry: got %b want 0", carry_out); end
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_plain_sum();
        int lat;
        send_word(8'h05, 8'h03, lat);
        n_cmp++; if (lat !== 8) begin n_bad++; $display("FAIL plain_latency: got %0d want 8", lat); end
        n_cmp++; if (minuend_out !== 8'h08) begin n_bad++; $display("FAIL plain_minuend: got %h want 08", minuend_out); end
        n_cmp++; if (carry_out !== 1'b0) begin n_bad++; $display("FAIL plain_carry: got %b want 0", carry_out); end
        n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL plain_in_ready_done: got %b want 0", in_ready); end
        release_word();
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL plain_out_valid_idle: got %b want 0", out_valid); end
        n_cmp++; if (minuend_out !== 8'h08) begin n_bad++; $display("FAIL plain_hold_idle: got %h want 08", minuend_out); end
    endtask

    task automatic test_borrow();
        int lat;
        send_word(8'hFE, 8'h03, lat);
        n_cmp++; if (minuend_out !== 8'h01) begin n_bad++; $display("FAIL borrow_minuend: got %h want 01", minuend_out); end
        n_cmp++; if (carry_out !== 1'b1) begin n_bad++; $display("FAIL borrow_carry: got %b want 1", carry_out); end
        release_word();
    endtask

    task automatic test_ripple();
        int lat;
        send_word(8'hFF, 8'h01, lat);
        n_cmp++; if (minuend_out !== 8'h00) begin n_bad++; $display("FAIL ripple_minuend: got %h want 00", minuend_out); end
        n_cmp++; if (carry_out !== 1'b1) begin n_bad++; $display("FAIL ripple_carry: got %b want 1", carry_out); end
        release_word();
        send_word(8'h00, 8'h00, lat);
        n_cmp++; if (minuend_out !== 8'h00) begin n_bad++; $display("FAIL zero_minuend: got %h want 00", minuend_out); end
        n_cmp++; if (carry_out !== 1'b0) begin n_bad++; $display("FAIL zero_carry: got %b want 0", carry_out); end
        release_word();
    endtask

    task automatic test_backpressure();
        int lat;
        send_word(8'h12, 8'h34, lat);
        diff_in = 8'hAA; sub_in = 8'h55; in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL bp_out_valid[%0d]: got %b want 1", i, out_valid); end
            n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL bp_in_ready[%0d]: got %b want 0", i, in_ready); end
            n_cmp++; if (minuend_out !== 8'h46) begin n_bad++; $display("FAIL bp_minuend[%0d]: got %h want 46", i, minuend_out); end
            n_cmp++; if (carry_out !== 1'b0) begin n_bad++; $display("FAIL bp_carry[%0d]: got %b want 0", i, carry_out); end
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL bp_idle_in_ready: got %b want 1", in_ready); end
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL bp_idle_out_valid: got %b want 0", out_valid); end
        send_word(8'hAA, 8'h55, lat);
        n_cmp++; if (lat !== 8) begin n_bad++; $display("FAIL bp_next_latency: got %0d want 8", lat); end
        n_cmp++; if (minuend_out !== 8'hFF) begin n_bad++; $display("FAIL bp_next_minuend: got %h want FF", minuend_out); end
        n_cmp++; if (carry_out !== 1'b0) begin n_bad++; $display("FAIL bp_next_carry: got %b want 0", carry_out); end
        release_word();
    endtask

    task automatic test_reset_mid_run();
        int lat;
        diff_in = 8'hF7; sub_in = 8'h11; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        rst_n = 1'b0;
        #1;
        n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL mid_rst_in_ready: got %b want 1", in_ready); end
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL mid_rst_out_valid: got %b want 0", out_valid); end
        n_cmp++; if (minuend_out !== 8'h00) begin n_bad++; $display("FAIL mid_rst_minuend: got %h want 00", minuend_out); end
        n_cmp++; if (carry_out !== 1'b0) begin n_bad++; $display("FAIL mid_rst_carry: got %b want 0", carry_out); end
        @(negedge clk); rst_n = 1'b1;
        send_word(8'h10, 8'h20, lat);
        n_cmp++; if (lat !== 8) begin n_bad++; $display("FAIL post_rst_latency: got %0d want 8", lat); end
        n_cmp++; if (minuend_out !== 8'h30) begin n_bad++; $display("FAIL post_rst_minuend: got %h want 30", minuend_out); end
        n_cmp++; if (carry_out !== 1'b0) begin n_bad++; $display("FAIL post_rst_carry: got %b want 0", carry_out); end
        release_word();
    endtask

    task automatic test_back_to_back();
        logic [7:0] d_tab [3] = '{8'h40, 8'h80, 8'h3C};
        logic [7:0] b_tab [3] = '{8'h40, 8'h80, 8'hC3};
        logic [7:0] m_tab [3] = '{8'h80, 8'h00, 8'hFF};
        logic       c_tab [3] = '{1'b0, 1'b1, 1'b0};
        int acc [3];
        int n;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            diff_in = d_tab[i];
            sub_in  = b_tab[i];
            n = 0;
            while (!in_ready && n < 30) begin @(posedge clk); #1; n++; end
            @(posedge clk); #1;
            acc[i] = cyc;
            n = 0;
            while (!out_valid && n < 30) begin @(posedge clk); #1; n++; end
            n_cmp++; if (minuend_out !== m_tab[i]) begin n_bad++; $display("FAIL b2b_minuend[%0d]: got %h want %h", i, minuend_out, m_tab[i]); end
            n_cmp++; if (carry_out !== c_tab[i]) begin n_bad++; $display("FAIL b2b_carry[%0d]: got %b want %b", i, carry_out, c_tab[i]); end
        end
        in_valid = 1'b0;
        @(posedge clk); #1;
        out_ready = 1'b0;
        for (int i = 1; i < 3; i++) begin
            n_cmp++; if (acc[i] - acc[i-1] !== 10) begin n_bad++; $display("FAIL b2b_spacing[%0d]: got %0d want 10", i, acc[i] - acc[i-1]); end
        end
    endtask

    initial begin
        test_reset();
        test_plain_sum();
        test_borrow();
        test_ripple();
        test_backpressure();
        test_reset_mid_run();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_serial_minuend_recover
